vec_alu_sequencer: RTL and testbench

Element sequencer directly upstream of the vector ALU block. Accepts one vector arithmetic command (vadd/vmul/vdot and variable-precision variants), walks the vector register file one 32-bit word at a time, presents opA/opB/opC to the ALU, holds the request until the ALU reports done, and writes each result back to the destination register. It also guarantees the ALU request drops between words, which the processing element needs in order to return to its start state.

---
 rtl/vec_alu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_vec_alu_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_sequencer.sv
// Vector ALU element sequencer: walks the vector register file one word at a time,
// feeds the ALU and writes results back. VSEQ_TIMEOUT_EN enables the per-word ALU watchdog.
module vec_alu_sequencer #(
  parameter int IDX_W = 5
`ifdef VSEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [7:0]           cmd_instr_i,
  input  logic [4:0]           cmd_vd_i,
  input  logic [4:0]           cmd_vs1_i,
  input  logic [4:0]           cmd_vs2_i,
  input  logic [IDX_W:0]       cmd_vl_i,
  output logic [5+IDX_W-1:0]   rf_raddr_a_o,
  output logic [5+IDX_W-1:0]   rf_raddr_b_o,
  output logic [5+IDX_W-1:0]   rf_raddr_c_o,
  input  logic [31:0]          rf_rdata_a_i,
  input  logic [31:0]          rf_rdata_b_i,
  input  logic [31:0]          rf_rdata_c_i,
  output logic                 rf_we_o,
  output logic [5+IDX_W-1:0]   rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  output logic [7:0]           alu_instr_o,
  output logic                 alu_req_o,
  output logic [31:0]          alu_opa_o,
  output logic [31:0]          alu_opb_o,
  output logic [31:0]          alu_opc_o,
  input  logic [31:0]          alu_result_i,
  input  logic                 alu_done_i,
  output logic                 seq_done_o,
  output logic                 seq_err_o
);

  // state   | meaning
  // IDLE    | ready for a command
  // READ    | register-file addresses for word idx presented
  // WAIT_RD | read data returns, captured as ALU operands
  // EXEC    | alu_req held until alu_done
  // WB      | result written to {vd, idx}; alu_req low
  // FIN     | seq_done pulse
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [2:0]     state_q, state_d;
  logic [7:0]     instr_q;
  logic [4:0]     vd_q, vs1_q, vs2_q;
  logic [IDX_W:0] vl_q, idx_q;
  logic [31:0]    opa_q, opb_q, opc_q, res_q;
  logic           last_word;
  logic           tmo_hit;

  // idx is one bit wider than a word index so vl = 2^IDX_W compares without wrapping
  assign last_word = (idx_q == (vl_q - ONE));

`ifdef VSEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_q;
  logic       err_q;

  assign tmo_hit = (state_q == S_EXEC) && !alu_done_i && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state_q == S_WAIT_RD)
        tmo_q <= 8'd0;
      else if (state_q == S_EXEC)
        tmo_q <= tmo_q + 8'd1;
    end
  end

  assign seq_err_o = err_q;
`else
  assign tmo_hit   = 1'b0;
  assign seq_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cmd_valid_i) state_d = (cmd_vl_i == '0) ? S_FIN : S_READ;
      S_READ:    state_d = S_WAIT_RD;
      S_WAIT_RD: state_d = S_EXEC;
      S_EXEC: begin
        if (alu_done_i)   state_d = S_WB;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_WB:      state_d = last_word ? S_FIN : S_READ;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      instr_q <= 8'd0;
      vd_q    <= 5'd0;
      vs1_q   <= 5'd0;
      vs2_q   <= 5'd0;
      vl_q    <= '0;
      idx_q   <= '0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      opc_q   <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            instr_q <= cmd_instr_i;
            vd_q    <= cmd_vd_i;
            vs1_q   <= cmd_vs1_i;
            vs2_q   <= cmd_vs2_i;
            vl_q    <= cmd_vl_i;
            idx_q   <= '0;
          end
        end
        S_WAIT_RD: begin
          opa_q <= rf_rdata_a_i;
          opb_q <= rf_rdata_b_i;
          opc_q <= rf_rdata_c_i;
        end
        S_EXEC: if (alu_done_i) res_q <= alu_result_i;
        S_WB:   if (!last_word) idx_q <= idx_q + ONE;
        default: ;
      endcase
    end
  end

  // ready is qualified by resetn so it reads 0 for the whole reset window
  assign cmd_ready_o  = resetn && (state_q == S_IDLE);
  assign rf_raddr_a_o = (state_q == S_READ) ? {vs1_q, idx_q[IDX_W-1:0]} : '0;
  assign rf_raddr_b_o = (state_q == S_READ) ? {vs2_q, idx_q[IDX_W-1:0]} : '0;
  assign rf_raddr_c_o = (state_q == S_READ) ? {vd_q,  idx_q[IDX_W-1:0]} : '0;
  assign rf_we_o      = (state_q == S_WB);
  assign rf_waddr_o   = (state_q == S_WB) ? {vd_q, idx_q[IDX_W-1:0]} : '0;
  assign rf_wdata_o   = (state_q == S_WB) ? res_q : 32'd0;
  assign alu_instr_o  = instr_q;
  assign alu_req_o    = (state_q == S_EXEC);
  assign alu_opa_o    = opa_q;
  assign alu_opb_o    = opb_q;
  assign alu_opc_o    = opc_q;
  assign seq_done_o   = (state_q == S_FIN);

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Self-checking bench for vec_alu_sequencer: register-file and ALU models around the DUT,
// expected writes and timing derived from a word-level reference model.
module tb_vec_alu_sequencer;
  localparam int AW = 10;

  logic        clk;
  logic        resetn;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_instr;
  logic [4:0]  cmd_vd, cmd_vs1, cmd_vs2;
  logic [5:0]  cmd_vl;
  logic [9:0]  rf_raddr_a, rf_raddr_b, rf_raddr_c, rf_waddr;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_rdata_c, rf_wdata;
  logic        rf_we;
  logic [7:0]  alu_instr;
  logic        alu_req, alu_done, seq_done, seq_err;
  logic [31:0] alu_opa, alu_opb, alu_opc, alu_result;

  vec_alu_sequencer dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_instr_i(cmd_instr),
    .cmd_vd_i(cmd_vd), .cmd_vs1_i(cmd_vs1), .cmd_vs2_i(cmd_vs2), .cmd_vl_i(cmd_vl),
    .rf_raddr_a_o(rf_raddr_a), .rf_raddr_b_o(rf_raddr_b), .rf_raddr_c_o(rf_raddr_c),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b), .rf_rdata_c_i(rf_rdata_c),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .alu_instr_o(alu_instr), .alu_req_o(alu_req),
    .alu_opa_o(alu_opa), .alu_opb_o(alu_opb), .alu_opc_o(alu_opc),
    .alu_result_i(alu_result), .alu_done_i(alu_done),
    .seq_done_o(seq_done), .seq_err_o(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model: registered read, preload port for test setup
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    rf_rdata_a <= mem[rf_raddr_a];
    rf_rdata_b <= mem[rf_raddr_b];
    rf_rdata_c <= mem[rf_raddr_c];
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (rf_we) mem[rf_waddr] <= rf_wdata;
  end

  function automatic logic [31:0] alu_fn(input logic [7:0] op, input logic [31:0] a, b, c);
    case (op)
      8'h00:   return a + b;
      8'h01:   return a * b;
      8'h02:   return c + a * b;
      default: return a ^ b ^ {24'd0, op};
    endcase
  endfunction

  // ALU model: done in the k-th cycle of a request (k = alu_lat, 0 = never)
  int   alu_lat;
  int   alu_cnt;
  logic spur;
  bit   spur_en;
  always @(posedge clk) alu_cnt <= alu_req ? alu_cnt + 1 : 0;
  always @(negedge clk) spur <= spur_en && !alu_req && ($urandom_range(0, 3) == 0);
  assign alu_done   = (alu_req && alu_lat > 0 && alu_cnt == alu_lat - 1) || spur;
  assign alu_result = alu_fn(alu_instr, alu_opa, alu_opb, alu_opc);

  int total, bad;

  // per-command trace; cycle c=1 is the cycle after the accepting edge
  logic        tr_req [0:511];
  logic        tr_we [0:511];
  logic        tr_ready [0:511];
  logic [9:0]  tr_raddr_c [0:511];
  logic [31:0] tr_opc [0:511];
  logic [9:0]  w_addr [0:63];
  logic [31:0] w_data [0:63];
  int          w_cyc [0:63];
  int          nw, n_done, c_done, n_err, c_err, n_cyc;
  bit          tmo;
  logic        ready0;
  logic [9:0]  exp_addr [0:63];
  logic [31:0] exp_data [0:63];
  logic [31:0] exp_opc [0:63];

  function automatic logic [9:0] mk(input logic [4:0] r, input int i);
    logic [4:0] w;
    w = i[4:0];
    return {r, w};
  endfunction

  function automatic logic exp_req(input int c, input int k, input int vl);
    int p;
    if (c < 1 || c > vl * (k + 3)) return 1'b0;
    p = (c - 1) % (k + 3);
    return (p >= 2 && p < 2 + k);
  endfunction

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic preload_rand(input logic [4:0] r, input int n);
    for (int i = 0; i < n; i++) preload(mk(r, i), $urandom);
  endtask

  task automatic model_cmd(input logic [7:0] op, input logic [4:0] vd, vs1, vs2, input int n);
    for (int i = 0; i < n; i++) begin
      exp_opc[i]  = ref_mem[mk(vd, i)];
      exp_addr[i] = mk(vd, i);
      exp_data[i] = alu_fn(op, ref_mem[mk(vs1, i)], ref_mem[mk(vs2, i)], exp_opc[i]);
      ref_mem[mk(vd, i)] = exp_data[i];
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [4:0] vd, vs1, vs2,
                         input logic [5:0] vl, input int k, input int rst_at, input int poke_at);
    int  c, end_c;
    bit  stop;
    alu_lat = k; nw = 0; n_done = 0; c_done = -1; n_err = 0; c_err = -1; tmo = 0;
    ready0 = cmd_ready;
    cmd_instr = op; cmd_vd = vd; cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vl = vl;
    cmd_valid = 1'b1;
    @(posedge clk);
    c = 0; end_c = 0; stop = 0;
    while (!stop) begin
      @(negedge clk);
      c++;
      cmd_valid = 1'b0;
      tr_req[c] = alu_req; tr_we[c] = rf_we; tr_ready[c] = cmd_ready;
      tr_raddr_c[c] = rf_raddr_c; tr_opc[c] = alu_opc;
      if (rf_we && nw < 64) begin
        w_addr[nw] = rf_waddr; w_data[nw] = rf_wdata; w_cyc[nw] = c; nw++;
      end
      if (seq_done) begin n_done++; c_done = c; end
      if (seq_err) begin n_err++; c_err = c; end
      if ((seq_done || seq_err) && end_c == 0) end_c = c + 2;
      if (rst_at > 0) begin
        resetn = (c != rst_at);
        if (c == rst_at) end_c = rst_at + 3;
      end
      if (c == poke_at) begin
        cmd_valid = 1'b1; cmd_instr = 8'h07; cmd_vd = vd ^ 5'h1f; cmd_vl = 6'd1;
      end
      if (c == end_c) stop = 1;
      if (c >= 500) begin tmo = 1; stop = 1; end
    end
    n_cyc = c;
    cmd_valid = 1'b0; resetn = 1'b1; alu_lat = 1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, rf_we, alu_req, seq_done, seq_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {cmd_ready, rf_we, alu_req, seq_done, seq_err});
    end
    total++;
    if ({rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b, rf_raddr_c, alu_instr, alu_opa, alu_opb, alu_opc} !== '0) begin
      bad++; $display("FAIL reset_data got nonzero addr/data/operand outputs");
    end
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_vadd();
    int k, errs, run, min_gap;
    bit hi_seen;
    k = 2;
    for (int i = 0; i < 4; i++) begin
      preload(mk(5'd3, i), 32'h01020304 + i);
      preload(mk(5'd4, i), 32'h10101010);
      preload(mk(5'd5, i), $urandom);
    end
    model_cmd(8'h00, 5'd5, 5'd3, 5'd4, 4);
    run_cmd(8'h00, 5'd5, 5'd3, 5'd4, 6'd4, k, 0, 0);
    total++;
    if (ready0 !== 1'b1 || tmo) begin bad++; $display("FAIL vadd_run ready0=%b budget_out=%0d want 1/0", ready0, tmo); end
    total++;
    if (nw != 4) begin bad++; $display("FAIL vadd_nwrites got=%0d want=4", nw); end
    for (int i = 0; i < nw && i < 4; i++) begin
      total++;
      if (w_addr[i] !== mk(5'd5, i) || w_data[i] !== 32'h11121314 + i || w_data[i] !== exp_data[i] || w_cyc[i] != (i + 1) * (k + 3)) begin
        bad++;
        $display("FAIL vadd_write%0d got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 i, w_addr[i], w_data[i], w_cyc[i], mk(5'd5, i), 32'h11121314 + i, (i + 1) * (k + 3));
      end
    end
    total++;
    if (n_done != 1 || c_done != 4 * (k + 3) + 1) begin
      bad++; $display("FAIL vadd_done got count=%0d cyc=%0d want 1/%0d", n_done, c_done, 4 * (k + 3) + 1);
    end
    errs = 0; run = 0; min_gap = 1000; hi_seen = 0;
    for (int c = 1; c <= n_cyc; c++) begin
      if (tr_req[c] !== exp_req(c, k, 4)) errs++;
      if (tr_req[c]) begin
        if (hi_seen && run > 0 && run < min_gap) min_gap = run;
        hi_seen = 1; run = 0;
      end else run++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL vadd_req_trace got %0d wrong cycles want 0", errs); end
    total++;
    if (min_gap < 3) begin bad++; $display("FAIL vadd_req_gap got=%0d want>=3", min_gap); end
    total++;
    if (c_done > 0 && (tr_ready[c_done] !== 1'b0 || tr_ready[c_done + 1] !== 1'b1)) begin
      bad++; $display("FAIL back_to_back_ready got fin=%b next=%b want 0/1", tr_ready[c_done], tr_ready[c_done + 1]);
    end
  endtask

  task automatic test_vl0();
    run_cmd(8'h00, 5'd9, 5'd1, 5'd2, 6'd0, 3, 0, 0);
    total++;
    if (nw != 0) begin bad++; $display("FAIL vl0_writes got=%0d want=0", nw); end
    total++;
    if (n_done != 1 || c_done != 1 || tmo) begin
      bad++; $display("FAIL vl0_done got count=%0d cyc=%0d want 1/1", n_done, c_done);
    end
  endtask

  task automatic test_vdot();
    int k, errs;
    k = 9;
    preload_rand(5'd10, 4); preload_rand(5'd11, 4); preload_rand(5'd7, 4);
    model_cmd(8'h02, 5'd7, 5'd10, 5'd11, 4);
    run_cmd(8'h02, 5'd7, 5'd10, 5'd11, 6'd4, k, 0, 0);
    total++;
    if (nw != 4 || n_done != 1 || tmo) begin bad++; $display("FAIL vdot_count got writes=%0d done=%0d want 4/1", nw, n_done); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tr_raddr_c[1 + i * (k + 3)] !== mk(5'd7, i) || tr_opc[3 + i * (k + 3)] !== exp_opc[i]) begin
        bad++;
        $display("FAIL vdot_opc%0d got raddr_c=%h opc=%h want %h/%h", i,
                 tr_raddr_c[1 + i * (k + 3)], tr_opc[3 + i * (k + 3)], mk(5'd7, i), exp_opc[i]);
      end
    end
    errs = 0;
    for (int i = 0; i < nw && i < 4; i++) begin
      if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i]) errs++;
      if (i > 0 && w_cyc[i] - w_cyc[i - 1] != 12) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL vdot_writes got %0d bad writes/spacings want 0", errs); end
  endtask

  task automatic test_ignore_busy();
    int errs;
    preload_rand(5'd12, 3); preload_rand(5'd13, 3); preload_rand(5'd14, 3);
    model_cmd(8'h00, 5'd14, 5'd12, 5'd13, 3);
    run_cmd(8'h00, 5'd14, 5'd12, 5'd13, 6'd3, 4, 0, 5);
    total++;
    if (tr_ready[5] !== 1'b0 || tr_req[5] !== 1'b1) begin
      bad++; $display("FAIL busy_ready got ready=%b req=%b want 0/1", tr_ready[5], tr_req[5]);
    end
    errs = 0;
    for (int i = 0; i < nw && i < 3; i++)
      if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i]) errs++;
    total++;
    if (nw != 3 || errs != 0 || n_done != 1 || c_done != 3 * 7 + 1) begin
      bad++; $display("FAIL busy_result got writes=%0d errs=%0d done=%0d@%0d want 3/0/1@22", nw, errs, n_done, c_done);
    end
  endtask

  task automatic test_reset_mid();
    int errs;
    preload_rand(5'd15, 4); preload_rand(5'd16, 4); preload_rand(5'd17, 4);
    model_cmd(8'h01, 5'd17, 5'd15, 5'd16, 2);
    run_cmd(8'h01, 5'd17, 5'd15, 5'd16, 6'd4, 9, 30, 0);
    total++;
    if (tr_req[30] !== 1'b1) begin bad++; $display("FAIL rstmid_in_exec got req=%b want 1", tr_req[30]); end
    total++;
    if (tr_req[31] !== 1'b0 || tr_we[31] !== 1'b0 || tr_ready[31] !== 1'b0 || tr_ready[32] !== 1'b1) begin
      bad++; $display("FAIL rstmid_after got req=%b we=%b ready=%b,%b want 0,0,0,1",
                      tr_req[31], tr_we[31], tr_ready[31], tr_ready[32]);
    end
    errs = 0;
    for (int i = 0; i < nw && i < 2; i++)
      if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i]) errs++;
    total++;
    if (nw != 2 || errs != 0 || n_done != 0) begin
      bad++; $display("FAIL rstmid_writes got writes=%0d errs=%0d done=%0d want 2/0/0", nw, errs, n_done);
    end
  endtask

  task automatic test_full_length();
    int errs;
    preload_rand(5'd20, 32); preload_rand(5'd21, 32); preload_rand(5'd22, 32);
    model_cmd(8'h01, 5'd22, 5'd20, 5'd21, 32);
    run_cmd(8'h01, 5'd22, 5'd20, 5'd21, 6'd32, 1, 0, 0);
    errs = 0;
    for (int i = 0; i < nw && i < 32; i++)
      if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i] || w_cyc[i] != (i + 1) * 4) errs++;
    total++;
    if (nw != 32 || errs != 0 || tmo) begin bad++; $display("FAIL full_writes got=%0d errs=%0d want 32/0", nw, errs); end
    total++;
    if (n_done != 1 || c_done != 32 * 4 + 1) begin
      bad++; $display("FAIL full_done got count=%0d cyc=%0d want 1/129", n_done, c_done);
    end
  endtask

  task automatic test_random();
    logic [7:0] op;
    logic [4:0] vd, vs1, vs2;
    int         vl, k, errs;
    spur_en = 1;
    for (int n = 0; n < 6; n++) begin
      op = 8'($urandom_range(0, 7));
      vd = 5'($urandom); vs1 = 5'($urandom); vs2 = 5'($urandom);
      vl = $urandom_range(0, 32); k = $urandom_range(1, 6);
      preload_rand(vs1, vl); preload_rand(vs2, vl); preload_rand(vd, vl);
      model_cmd(op, vd, vs1, vs2, vl);
      run_cmd(op, vd, vs1, vs2, 6'(vl), k, 0, 0);
      errs = 0;
      for (int i = 0; i < nw && i < vl; i++)
        if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i] || w_cyc[i] != (i + 1) * (k + 3)) errs++;
      total++;
      if (nw != vl || errs != 0 || tmo) begin
        bad++; $display("FAIL rnd%0d_writes op=%0d vl=%0d k=%0d got writes=%0d errs=%0d", n, op, vl, k, nw, errs);
      end
      total++;
      if (n_done != 1 || c_done != vl * (k + 3) + 1) begin
        bad++; $display("FAIL rnd%0d_done got count=%0d cyc=%0d want 1/%0d", n, n_done, c_done, vl * (k + 3) + 1);
      end
    end
    spur_en = 0;
    @(negedge clk);
  endtask

`ifdef VSEQ_TIMEOUT_EN
  task automatic test_timeout();
    preload_rand(5'd24, 1); preload_rand(5'd25, 1); preload_rand(5'd26, 1);
    run_cmd(8'h00, 5'd26, 5'd24, 5'd25, 6'd1, 0, 0, 0);
    total++;
    if (n_err != 1 || c_err != 3 + 255 || n_done != 0 || nw != 0) begin
      bad++; $display("FAIL timeout got err=%0d@%0d done=%0d writes=%0d want 1@258/0/0", n_err, c_err, n_done, nw);
    end
    total++;
    if (c_err > 0 && (tr_ready[c_err] !== 1'b1 || tr_req[c_err] !== 1'b0)) begin
      bad++; $display("FAIL timeout_idle got ready=%b req=%b want 1/0", tr_ready[c_err], tr_req[c_err]);
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_instr = 8'd0;
    cmd_vd = 5'd0; cmd_vs1 = 5'd0; cmd_vs2 = 5'd0; cmd_vl = 6'd0;
    pl_we = 1'b0; pl_addr = 10'd0; pl_data = 32'd0;
    alu_lat = 1; spur_en = 0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'd0;
    @(negedge clk);
    test_reset();
    test_vadd();
    test_vl0();
    test_vdot();
    test_ignore_busy();
    test_reset_mid();
    test_full_length();
    test_random();
`ifdef VSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
